uart_receiver_multimode: RTL and testbench
==========================================

UART_RECEIVER_MULTIMODE -- requirements
Module: uart_receiver_multimode

Interface
REQ-001 Parameter DATA_WIDTH, default 8, maximum data bits per frame; the block SHALL support values 5..16.
REQ-002 Parameter PRESCALE_WIDTH, default 6, width of the prescale input.
REQ-003 clk  input  1  sole clock; all state SHALL update on the rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 serial_data_in  input  1  UART line; idle high; LSB first.
REQ-006 prescale  input  PRESCALE_WIDTH  clk cycles per bit.
REQ-007 data_length  input  $clog2(DATA_WIDTH)+1  data bits per frame; legal range 5..DATA_WIDTH.
REQ-008 parity_enable  input  1  1 = a parity bit follows the data.
REQ-009 parity_type  input  1  0 = even, 1 = odd.
REQ-010 stop_bits  input  1  0 = one stop bit, 1 = two stop bits.
REQ-011 parallel_data  output  DATA_WIDTH  last good word, zero-extended above data_length.
REQ-012 data_valid  output  1  one-cycle pulse per good frame.
REQ-013 parity_error  output  1  one-cycle pulse.
REQ-014 frame_error  output  1  one-cycle pulse.
REQ-015 break_detected  output  1  one-cycle pulse; see Configuration.
REQ-016 busy  output  1  high whenever the FSM is not in IDLE.

Function
REQ-017 The FSM SHALL have the states IDLE, START, DATA, PARITY, STOP, RESULT (plus BREAK_WAIT when break detection is compiled in).
REQ-018 IDLE->START SHALL occur on the first clk that samples serial_data_in = 0; that cycle is bit-counter cycle 0.
REQ-019 Configuration SHALL be latched on that cycle: prescale, data_length, parity_enable, parity_type, stop_bits. Input changes mid-frame SHALL be ignored.
REQ-020 Prescale values below 4 SHALL be treated as 4.
REQ-021 data_length values outside 5..DATA_WIDTH SHALL be treated as DATA_WIDTH.
REQ-022 Each bit SHALL be the 2-of-3 majority of samples taken at counter values P/2-1, P/2 and P/2+1, with P the latched prescale and the counter running 0..P-1.
REQ-023 If the start-bit majority is 1, the FSM SHALL return to IDLE at counter P-1 with no flag asserted (glitch rejection).
REQ-024 Parity SHALL be computed over the data_length received bits.
REQ-025 The parity bit SHALL be wrong when it differs from the XOR of those bits (even parity) or from its complement (odd parity).
REQ-026 The frame is bad when any stop bit samples 0.
REQ-027 RESULT SHALL occur exactly P*(1+L+PE+S) cycles after the IDLE->START cycle, where L = data_length, PE = parity_enable, S = 1 or 2 stop bits.
REQ-028 RESULT SHALL last one cycle, then the FSM SHALL return to IDLE.
REQ-029 In RESULT, exactly one of data_valid, parity_error, frame_error SHALL pulse. frame_error has priority over parity_error.
REQ-030 parallel_data SHALL update only on a good frame, in the same cycle data_valid rises. On error it SHALL hold its previous value.
REQ-031 A start bit arriving in the cycle after RESULT SHALL be accepted (back-to-back frames).

Reset
REQ-032 While reset = 0 the FSM SHALL be in IDLE and the counters at 0.
REQ-033 While reset = 0, parallel_data SHALL be 0; data_valid, parity_error, frame_error, break_detected and busy SHALL be 0.
REQ-034 Reset asserted mid-frame SHALL abort the frame with no flag. After release the block SHALL wait for a fresh low sample.

Configuration
REQ-035 Macro UART_RX_BREAK_DETECT_EN controls break detection.
REQ-036 When UART_RX_BREAK_DETECT_EN is defined, a frame whose start, data, parity and stop samples are all 0 SHALL pulse break_detected in RESULT instead of frame_error.
REQ-037 After such a frame the FSM SHALL enter BREAK_WAIT and stay there until serial_data_in samples 1, then go to IDLE.
REQ-038 When the macro is undefined, break_detected SHALL be tied 0 and an all-zero frame SHALL report frame_error.

Verification (DATA_WIDTH=8, prescale=8)
REQ-039 8N1, byte 0xA5 -> data_valid pulse 80 cycles after start detection; parallel_data=0xA5; no error flags.
REQ-040 data_length=5, even parity, 2 stop bits, data 0x15 -> data_valid after 72 cycles; parallel_data=0x15, bits[7:5]=0.
REQ-041 0x3C with serial_data_in inverted for one clk at counter=P/2 of bit 2; separately a one-clk low pulse on the idle line -> first gives parallel_data=0x3C, second gives no pulse of any flag and busy low 8 cycles later.
REQ-042 Odd parity, 0x57 sent with an even parity bit -> parity_error pulse only; parallel_data keeps 0x3C.
REQ-043 stop_bits=1 with the second stop bit 0 -> frame_error only. Reset pulsed during bit 4 -> all outputs 0 and the next 0xA5 frame is received correctly.
REQ-044 Line held low for 12 bit times, 8N1 -> break_detected pulse and busy high until the line rises (macro defined); frame_error pulse (macro undefined).

Source files
------------

// File: rtl/uart_receiver_multimode.sv
// Multi-format UART receiver with 3-sample majority voting per bit.
// Define UART_RX_BREAK_DETECT_EN to add line-break detection (BREAK_WAIT state).
module uart_receiver_multimode #(
    parameter int DATA_WIDTH     = 8,
    parameter int PRESCALE_WIDTH = 6
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        serial_data_in,
    input  logic [PRESCALE_WIDTH-1:0]   prescale,
    input  logic [$clog2(DATA_WIDTH):0] data_length,
    input  logic                        parity_enable,
    input  logic                        parity_type,
    input  logic                        stop_bits,
    output logic [DATA_WIDTH-1:0]       parallel_data,
    output logic                        data_valid,
    output logic                        parity_error,
    output logic                        frame_error,
    output logic                        break_detected,
    output logic                        busy
);
    localparam int PW = PRESCALE_WIDTH;
    localparam int LW = $clog2(DATA_WIDTH) + 1;
    localparam logic [PW-1:0] P_MIN = PW'(4);
    localparam logic [LW-1:0] L_MIN = LW'(5);
    localparam logic [LW-1:0] L_MAX = LW'(DATA_WIDTH);

    typedef enum logic [2:0] {
        IDLE, START, DATA, PARITY, STOP, RESULT
`ifdef UART_RX_BREAK_DETECT_EN
        , BREAK_WAIT
`endif
    } state_t;

    typedef enum logic [1:0] {R_GOOD, R_PAR, R_FRAME, R_BREAK} res_t;

    state_t          state, nxt;
    res_t            res_r, res_n;
    logic [PW-1:0]   cnt, p_r, half;
    logic [LW-1:0]   len_r, bit_idx;
    logic            pe_r, pt_r, sb_r, stop_idx;
    logic            s_lo, s_mid, bit_r;
    logic            par_acc, par_err, stop_err;
    logic [DATA_WIDTH-1:0] shreg;
    logic            rx, in_bit, cnt_end;
    logic            at_lo, at_mid, at_hi, maj, bit_now;
    logic            last_data, last_stop, fin;
`ifdef UART_RX_BREAK_DETECT_EN
    logic            any_one;
`endif

    assign rx        = serial_data_in;
    assign half      = p_r >> 1;
    assign in_bit    = (state == START) || (state == DATA) ||
                       (state == PARITY) || (state == STOP);
    assign cnt_end   = cnt == p_r - 1'b1;
    assign at_lo     = cnt == half - 1'b1;
    assign at_mid    = cnt == half;
    assign at_hi     = cnt == half + 1'b1;
    assign maj       = (s_lo & s_mid) | (s_lo & rx) | (s_mid & rx);
    // With P=4 the last vote lands on the bit's final cycle, so use it directly.
    assign bit_now   = at_hi ? maj : bit_r;
    assign last_data = bit_idx == len_r - 1'b1;
    assign last_stop = stop_idx == sb_r;
    assign fin       = (state == STOP) && cnt_end && last_stop;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= nxt;
    end

    always_comb begin
        nxt = state;
        unique case (state)
            IDLE:   if (!rx) nxt = START;
            START:  if (cnt_end) nxt = bit_now ? IDLE : DATA;
            DATA:   if (cnt_end && last_data) nxt = pe_r ? PARITY : STOP;
            PARITY: if (cnt_end) nxt = STOP;
            STOP:   if (fin) nxt = RESULT;
`ifdef UART_RX_BREAK_DETECT_EN
            RESULT:     nxt = (res_r == R_BREAK) ? BREAK_WAIT : IDLE;
            BREAK_WAIT: if (rx) nxt = IDLE;
`else
            RESULT: nxt = IDLE;
`endif
            default: nxt = IDLE;
        endcase
    end

    always_comb begin
        res_n = R_GOOD;
        if (stop_err || !bit_now) res_n = R_FRAME;
        else if (par_err)         res_n = R_PAR;
`ifdef UART_RX_BREAK_DETECT_EN
        if (!(any_one || bit_now)) res_n = R_BREAK;
`endif
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt           <= '0;
            bit_idx       <= '0;
            stop_idx      <= 1'b0;
            p_r           <= P_MIN;
            len_r         <= L_MAX;
            pe_r          <= 1'b0;
            pt_r          <= 1'b0;
            sb_r          <= 1'b0;
            s_lo          <= 1'b1;
            s_mid         <= 1'b1;
            bit_r         <= 1'b1;
            par_acc       <= 1'b0;
            par_err       <= 1'b0;
            stop_err      <= 1'b0;
            shreg         <= '0;
            res_r         <= R_GOOD;
            parallel_data <= '0;
`ifdef UART_RX_BREAK_DETECT_EN
            any_one       <= 1'b0;
`endif
        end else begin
            if (state == IDLE) begin
                cnt      <= '0;
                bit_idx  <= '0;
                stop_idx <= 1'b0;
                if (!rx) begin
                    p_r      <= (prescale < P_MIN) ? P_MIN : prescale;
                    len_r    <= (data_length < L_MIN || data_length > L_MAX)
                                ? L_MAX : data_length;
                    pe_r     <= parity_enable;
                    pt_r     <= parity_type;
                    sb_r     <= stop_bits;
                    shreg    <= '0;
                    par_acc  <= 1'b0;
                    par_err  <= 1'b0;
                    stop_err <= 1'b0;
`ifdef UART_RX_BREAK_DETECT_EN
                    any_one  <= 1'b0;
`endif
                end
            end else if (in_bit) begin
                cnt <= cnt_end ? '0 : cnt + 1'b1;
                if (at_lo)  s_lo  <= rx;
                if (at_mid) s_mid <= rx;
                if (at_hi) begin
                    bit_r <= maj;
`ifdef UART_RX_BREAK_DETECT_EN
                    any_one <= any_one | maj;
`endif
                    if (state == DATA) begin
                        shreg   <= shreg | (DATA_WIDTH'(maj) << bit_idx);
                        par_acc <= par_acc ^ maj;
                    end
                    if (state == PARITY) par_err <= maj ^ par_acc ^ pt_r;
                    if (state == STOP && !maj) stop_err <= 1'b1;
                end
                if (cnt_end && state == DATA) bit_idx  <= bit_idx + 1'b1;
                if (cnt_end && state == STOP) stop_idx <= 1'b1;
            end
            if (fin) begin
                res_r <= res_n;
                if (res_n == R_GOOD) parallel_data <= shreg;
            end
        end
    end

    always_comb begin
        busy         = state != IDLE;
        data_valid   = (state == RESULT) && (res_r == R_GOOD);
        parity_error = (state == RESULT) && (res_r == R_PAR);
        frame_error  = (state == RESULT) && (res_r == R_FRAME);
`ifdef UART_RX_BREAK_DETECT_EN
        break_detected = (state == RESULT) && (res_r == R_BREAK);
`else
        break_detected = 1'b0;
`endif
    end

endmodule

// File: tb/tb_uart_receiver_multimode.sv
// Bench for uart_receiver_multimode: frame table plus scoreboard of result pulses.
// Honours UART_RX_BREAK_DETECT_EN for the line-break case.
module tb_uart_receiver_multimode;
    localparam int DW = 8;
    localparam int PW = 6;
    localparam int LW = 4;
    localparam logic [3:0] DV = 4'b0001;
    localparam logic [3:0] PE = 4'b0010;
    localparam logic [3:0] FE = 4'b0100;
    localparam logic [3:0] BD = 4'b1000;

    logic          clk = 1'b0;
    logic          reset;
    logic          rx;
    logic [PW-1:0] prescale;
    logic [LW-1:0] data_length;
    logic          pen, ptype, sbits;
    logic [DW-1:0] parallel_data;
    logic          data_valid, parity_error, frame_error;
    logic          break_detected, busy;

    uart_receiver_multimode #(.DATA_WIDTH(DW), .PRESCALE_WIDTH(PW)) dut (
        .clk            (clk),
        .reset          (reset),
        .serial_data_in (rx),
        .prescale       (prescale),
        .data_length    (data_length),
        .parity_enable  (pen),
        .parity_type    (ptype),
        .stop_bits      (sbits),
        .parallel_data  (parallel_data),
        .data_valid     (data_valid),
        .parity_error   (parity_error),
        .frame_error    (frame_error),
        .break_detected (break_detected),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [7:0] data;
        int         len;
        int         pre;
        bit         pe, pt, sb;
        bit         flip_par, bad_stop, glitch;
        logic [3:0] flags;
        logic [7:0] edata;
        int         lat;
    } vec_t;

    typedef struct {
        logic [3:0] flags;
        logic [7:0] data;
        int         cyc;
        int         id;
    } exp_t;

    vec_t tbl [12];
    exp_t q [$];
    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h required=%0h", name, got, exp);
        end
    endtask

    task automatic monitor();
        exp_t e;
        logic [3:0] f;
        forever begin
            @(negedge clk);
            f = {break_detected, frame_error, parity_error, data_valid};
            if (f != 4'b0) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_flag flags=%b data=%h required=none",
                             f, parallel_data);
                end else begin
                    e = q.pop_front();
                    if (f !== e.flags || parallel_data !== e.data || cyc != e.cyc) begin
                        errors++;
                        $display("FAIL frame%0d flags=%b data=%h cyc=%0d required flags=%b data=%h cyc=%0d",
                                 e.id, f, parallel_data, cyc, e.flags, e.data, e.cyc);
                    end
                end
            end else if (q.size() != 0 && cyc > q[0].cyc) begin
                checks++;
                errors++;
                e = q.pop_front();
                $display("FAIL frame%0d timeout got=no_flag required flags=%b at cyc=%0d",
                         e.id, e.flags, e.cyc);
            end
        end
    endtask

    task automatic send_frame(input int id, input vec_t v, input int abort_bit);
        logic fb [0:19];
        int p, l, n;
        logic par;
        exp_t e;
        p = (v.pre < 4) ? 4 : v.pre;
        l = (v.len < 5 || v.len > DW) ? DW : v.len;
        n = 0;
        par = 1'b0;
        fb[n] = 1'b0;
        n++;
        for (int i = 0; i < l; i++) begin
            fb[n] = v.data[i];
            par = par ^ v.data[i];
            n++;
        end
        if (v.pe) begin
            fb[n] = par ^ v.pt ^ v.flip_par;
            n++;
        end
        fb[n] = 1'b1;
        n++;
        if (v.sb) begin
            fb[n] = ~v.bad_stop;
            n++;
        end
        for (int b = 0; b < n; b++) begin
            for (int j = 0; j < p; j++) begin
                @(negedge clk);
                rx = fb[b];
                if (b == 0 && j == 0) begin
                    prescale    = PW'(v.pre);
                    data_length = LW'(v.len);
                    pen         = v.pe;
                    ptype       = v.pt;
                    sbits       = v.sb;
                    if (abort_bit < 0) begin
                        e.flags = v.flags;
                        e.data  = v.edata;
                        e.cyc   = cyc + 1 + v.lat;
                        e.id    = id;
                        q.push_back(e);
                    end
                end
                if (b == 0 && j == 1) begin
                    prescale    = PW'($urandom);
                    data_length = LW'($urandom);
                    pen         = 1'($urandom);
                    ptype       = 1'($urandom);
                    sbits       = 1'($urandom);
                end
                if (v.glitch && b == 3 && j == p / 2 + 1) rx = ~fb[b];
                if (b == abort_bit && j == p / 2) begin
                    reset = 1'b0;
                    rx    = 1'b1;
                    repeat (3) @(negedge clk);
                    check("abort_data",   32'(parallel_data), 32'h0);
                    check("abort_busy",   32'(busy), 32'h0);
                    check("abort_flags",
                          32'({break_detected, frame_error, parity_error, data_valid}),
                          32'h0);
                    reset = 1'b1;
                    repeat (3) @(negedge clk);
                    return;
                end
            end
        end
        @(negedge clk);
        rx = 1'b1;
        @(negedge clk);
        rx = 1'b1;
    endtask

    initial begin
        exp_t e;
        tbl[0]  = '{8'hA5, 8, 8,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, DV, 8'hA5, 80};
        tbl[1]  = '{8'hF5, 5, 8,  1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, DV, 8'h15, 72};
        tbl[2]  = '{8'h3C, 8, 8,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, DV, 8'h3C, 80};
        tbl[3]  = '{8'h57, 8, 8,  1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, PE, 8'h3C, 88};
        tbl[4]  = '{8'h81, 8, 8,  1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, FE, 8'h3C, 88};
        tbl[5]  = '{8'h00, 8, 8,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, DV, 8'h00, 80};
        tbl[6]  = '{8'hC3, 3, 8,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, DV, 8'hC3, 80};
        tbl[7]  = '{8'hFF, 7, 8,  1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, DV, 8'h7F, 80};
        tbl[8]  = '{8'h2A, 6, 8,  1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, FE, 8'h7F, 80};
        tbl[9]  = '{8'h5A, 8, 2,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, DV, 8'h5A, 40};
        tbl[10] = '{8'hFF, 8, 4,  1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, DV, 8'hFF, 48};
        tbl[11] = '{8'h96, 8, 13, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, DV, 8'h96, 130};

        reset = 1'b0;
        rx = 1'b1;
        prescale = 8;
        data_length = 8;
        pen = 1'b0;
        ptype = 1'b0;
        sbits = 1'b0;
        fork
            monitor();
        join_none

        repeat (3) @(negedge clk);
        check("rst_data",  32'(parallel_data), 32'h0);
        check("rst_dv",    32'(data_valid), 32'h0);
        check("rst_pe",    32'(parity_error), 32'h0);
        check("rst_fe",    32'(frame_error), 32'h0);
        check("rst_bd",    32'(break_detected), 32'h0);
        check("rst_busy",  32'(busy), 32'h0);
        reset = 1'b1;
        repeat (3) @(negedge clk);

        for (int i = 0; i < 12; i++) send_frame(i, tbl[i], -1);
        repeat (4) @(negedge clk);

        // One-clock low blip on an idle line must be rejected as a start bit.
        @(negedge clk);
        rx = 1'b0;
        prescale = 8;
        @(negedge clk);
        rx = 1'b1;
        check("blip_busy_start", 32'(busy), 32'h1);
        repeat (7) @(negedge clk);
        check("blip_busy_last", 32'(busy), 32'h1);
        @(negedge clk);
        check("blip_busy_idle", 32'(busy), 32'h0);
        check("blip_data_hold", 32'(parallel_data), 32'h96);
        repeat (4) @(negedge clk);

        send_frame(20, tbl[0], 5);
        send_frame(21, tbl[0], -1);
        repeat (4) @(negedge clk);

        // Line held low for twelve bit times.
        @(negedge clk);
        rx = 1'b0;
        prescale = 8;
        data_length = 8;
        pen = 1'b0;
        sbits = 1'b0;
`ifdef UART_RX_BREAK_DETECT_EN
        e.flags = BD;
`else
        e.flags = FE;
`endif
        e.data = 8'hA5;
        e.cyc  = cyc + 1 + 80;
        e.id   = 22;
        q.push_back(e);
        repeat (95) @(negedge clk);
        check("break_busy_low", 32'(busy), 32'h1);
        @(negedge clk);
        rx = 1'b1;
        @(negedge clk);
`ifdef UART_RX_BREAK_DETECT_EN
        check("break_busy_after_rise", 32'(busy), 32'h0);
`else
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
`endif
        repeat (20) @(negedge clk);
        check("queue_drained", 32'(q.size()), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
